// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// Over-samples the asynchronous rx line with clk_i, rejects start glitches
// shorter than half a bit, checks the stop bit, and hands each good byte to
// the consumer over a valid/ready handshake. Framing errors and overruns are
// reported as one-cycle pulses.

module uart_rx #(
    parameter int CLKS_PER_BIT = 10000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    // Delay from start-edge detection to the start-bit mid-sample.
    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    // Terminal counts, pre-sized to the 16-bit cycle counter.
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Synchronizer
    logic sync1;
    logic sync2;

    // FSM state and datapath registers
    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_next;
    logic [7:0]  shreg;
    logic [7:0]  shreg_next;

    // Next values of the registered outputs
    logic [7:0]  data_next;
    logic        valid_next;
    logic        frame_err_next;
    logic        overrun_next;

    // Two-flop synchronizer on the asynchronous line; idles high so reset
    // cannot fake a start edge.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments let sync2 take the old sync1, forming
        // a real two-stage shift; blocking here would collapse it to one flop.
        if (reset_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_i;
            sync2 <= sync1;
        end
    end

    // Next-state, counter, shift register and output decisions.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would infer a latch.
        state_next     = state;
        cnt_next       = cnt + 16'd1;
        bit_next       = bit_idx;
        shreg_next     = shreg;
        data_next      = rx_data_o;
        valid_next     = valid_o;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;

        // Consumer takes the byte; a load in STOP below may re-assert valid.
        if (valid_o && ready_i) begin
            valid_next = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (!sync2) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end

            START: begin
                // Mid-start sample: a line already back high was a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (sync2) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        bit_next   = 3'd0;
                    end
                end
            end

            DATA: begin
                // Mid-bit sample; shifting in from the top leaves bit k in
                // shreg[k] after the eighth sample.
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {sync2, shreg[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end

            STOP: begin
                // Leave at mid-stop so a start edge right after the stop bit
                // is not missed.
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (!sync2) begin
                        frame_err_next = 1'b1;
                    end else if (!valid_o || ready_i) begin
                        data_next  = shreg;
                        valid_next = 1'b1;
                    end else begin
                        // Previous byte still pending: keep it, drop this one.
                        overrun_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State register plus all registered outputs; busy follows the state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data_o   <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            bit_idx     <= bit_next;
            shreg       <= shreg_next;
            rx_data_o   <= data_next;
            valid_o     <= valid_next;
            frame_err_o <= frame_err_next;
            overrun_o   <= overrun_next;
            busy_o      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clocks per bit.
// Frames are driven bit-accurately; bytes expected to be delivered are queued
// when sent and compared against bytes the monitor sees transferred.

module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] rx_data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .rx_i       (rx_i),
        .rx_data_o  (rx_data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge N it reads N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues and observed event counters
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         ferr_cnt     = 0;
    int         ovr_cnt      = 0;
    int         valid_cycles = 0;
    int         busy_cycles  = 0;
    int         rise_cyc     = -1;
    logic       valid_d      = 1'b0;

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid_o && ready_i) obs_q.push_back(rx_data_o);
        if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
        if (overrun_o) ovr_cnt <= ovr_cnt + 1;
        if (valid_o) valid_cycles <= valid_cycles + 1;
        if (busy_o) busy_cycles <= busy_cycles + 1;
        if (valid_o && !valid_d) rise_cyc <= cyc;
        valid_d <= valid_o;
    end

    int errors = 0;
    int checks = 0;
    int e0     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and land 2 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        e0   = cyc + 1;
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
        rx_i = stop_bit;
        tick(CPB);
        rx_i = 1'b1;
    endtask

    // Compare delivered bytes against expected ones, then empty both queues.
    task automatic drain(input string tag);
        logic [7:0] e;
        logic [7:0] o;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_data"}, o, e);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int f0;
        int o0;
        int v0;
        int b0;

        reset_i = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        tick(50);
        check("reset_data", rx_data_o, 8'h00);
        check("reset_valid", valid_o, 1'b0);
        check("reset_ferr", frame_err_o, 1'b0);
        check("reset_ovr", overrun_o, 1'b0);
        check("reset_busy", busy_o, 1'b0);
        reset_i = 1'b0;
        tick(5);

        // 1: single byte, latency and one-cycle valid
        f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
        exp_q.push_back(8'h6C);
        send_frame(8'h6C, 1'b1);
        tick(20);
        check("t1_latency", rise_cyc, e0 + LAT);
        check("t1_valid_cycles", valid_cycles - v0, 1);
        check("t1_ferr", ferr_cnt - f0, 0);
        check("t1_ovr", ovr_cnt - o0, 0);
        drain("t1");

        // 2: back-to-back frames
        f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
        exp_q.push_back(8'h88);
        exp_q.push_back(8'h6C);
        send_frame(8'h88, 1'b1);
        send_frame(8'h6C, 1'b1);
        tick(20);
        check("t2_valid_cycles", valid_cycles - v0, 2);
        check("t2_ferr", ferr_cnt - f0, 0);
        check("t2_ovr", ovr_cnt - o0, 0);
        drain("t2");

        // 3: overrun while the consumer stalls
        ready_i = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h88, 1'b1);
        send_frame(8'h6C, 1'b1);
        tick(10);
        check("t3_ovr", ovr_cnt - o0, 1);
        check("t3_valid_held", valid_o, 1'b1);
        check("t3_data_held", rx_data_o, 8'h88);
        check("t3_no_transfer", obs_q.size(), 0);
        exp_q.push_back(8'h88);
        ready_i = 1'b1;
        tick(1);
        check("t3_valid_drop", valid_o, 1'b0);
        tick(5);
        drain("t3");

        // 4: bad stop bit, then a good frame
        f0 = ferr_cnt; v0 = valid_cycles;
        send_frame(8'hA5, 1'b0);
        tick(30);
        check("t4_ferr", ferr_cnt - f0, 1);
        check("t4_no_valid", valid_cycles - v0, 0);
        check("t4_busy_idle", busy_o, 1'b0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(20);
        check("t4_ferr_after", ferr_cnt - f0, 1);
        drain("t4");

        // 5: short low glitch on an idle line
        f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles; b0 = busy_cycles;
        rx_i = 1'b0;
        tick(5);
        rx_i = 1'b1;
        tick(30);
        check("t5_busy_seen", (busy_cycles - b0) > 0, 1'b1);
        check("t5_busy_idle", busy_o, 1'b0);
        check("t5_no_valid", valid_cycles - v0, 0);
        check("t5_ferr", ferr_cnt - f0, 0);
        check("t5_ovr", ovr_cnt - o0, 0);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        tick(20);
        drain("t5");

        // 6: reset in the middle of 0x3C's data bits
        f0 = ferr_cnt; v0 = valid_cycles;
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx_i = (8'h3C >> i) & 8'h01;
            tick(CPB);
        end
        rx_i = 1'b1;
        tick(HALF);
        check("t6_busy_before", busy_o, 1'b1);
        reset_i = 1'b1;
        tick(1);
        reset_i = 1'b0;
        check("t6_rst_data", rx_data_o, 8'h00);
        check("t6_rst_valid", valid_o, 1'b0);
        check("t6_rst_busy", busy_o, 1'b0);
        check("t6_rst_ferr", frame_err_o, 1'b0);
        check("t6_rst_ovr", overrun_o, 1'b0);
        tick(40);
        check("t6_no_valid", valid_cycles - v0, 0);
        check("t6_ferr", ferr_cnt - f0, 0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        tick(20);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, the receive-side partner of uart_tx. It over-samples the asynchronous serial line with the system clock, rejects false starts, and checks the stop bit. Each received byte is delivered to the consumer over a valid/ready handshake. It sits between the device RX pin and the byte-level consumer logic.

Parameters:
CLKS_PER_BIT, 10000, clock cycles per bit; 10000 gives 10 kbaud at 100 MHz and matches uart_tx. Legal range 4..65535.
HALF_BIT, CLKS_PER_BIT/2, cycle count from start-edge detection to the start-bit mid-sample. Derived; not overridden.

Ports:
clk_i  in  1  system clock; all logic on the rising edge
reset_i  in  1  synchronous, active-high reset
rx_i  in  1  asynchronous serial input; idles high
rx_data_o  out  8  received byte; stable while valid_o=1
valid_o  out  1  rx_data_o holds an unconsumed byte
ready_i  in  1  consumer accepts the byte when valid_o & ready_i at a clock edge
frame_err_o  out  1  one-cycle pulse: stop bit sampled low
overrun_o  out  1  one-cycle pulse: good frame arrived while the previous byte was unconsumed
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (reset_i=1 at an edge):
  - Synchronizer flops sync1 and sync2 forced to 1.
  - FSM goes to IDLE; bit counter and cycle counter cleared.
  - rx_data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
  - Reset mid-frame abandons the frame with no pulses. A pending byte is discarded.
- Synchronizer: two flops on rx_i; all decisions use sync2.
- Cycle counter: 16 bits, cleared on every state transition, increments otherwise.
- FSM states:
  - IDLE: on sync2=0, go to START with cnt=0.
  - START: at cnt==HALF_BIT-1, sample sync2.
    - If 1: glitch; return to IDLE with no pulse.
    - If 0: go to DATA with bit index 0.
  - DATA: at cnt==CLKS_PER_BIT-1, shift sync2 into the shift register LSB first (bit k lands in shreg[k]).
    - After the 8th sample (index 7), go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample sync2 and go to IDLE on the same edge. Do not wait for end of bit; the next start edge must be detectable immediately.
    - sync2=1 and (valid_o=0 or ready_i=1): rx_data_o<=shreg, valid_o<=1.
    - sync2=1, valid_o=1, ready_i=0: overrun_o pulses; old byte kept; new byte dropped.
    - sync2=0: frame_err_o pulses; byte dropped; valid_o/rx_data_o unchanged.
- Latency: if rx_i is first low at edge E0, valid_o is high starting at edge E0+2+HALF_BIT+9*CLKS_PER_BIT.
- Handshake:
  - valid_o stays high until an edge with ready_i=1, then clears.
  - A simultaneous load and accept keeps valid_o=1 with the new data.
  - rx_data_o changes only on a load.
- Line held low (break):
  - Produces a frame with data 0x00 and frame_err_o.
  - FSM then returns to IDLE, sees sync2=0 and restarts. Another frame_err_o follows each frame period until the line goes high.
- busy_o = (state != IDLE), registered with the state.

Test Plan:
CLKS_PER_BIT=16 for all tests. The bench drives rx_i with a bit-accurate model (start 0, LSB first, stop 1).
1. Reset for 50 cycles, then release, then send 0x6C with ready_i=1 -> valid_o high for exactly 1 cycle at E0+2+8+144 cycles; rx_data_o=0x6C; frame_err_o=0; overrun_o=0.
2. Send 0x88, then 0x6C back-to-back, ready_i=1 -> two single-cycle valid_o pulses, data 0x88 then 0x6C; no errors.
3. ready_i=0, send 0x88 then 0x6C -> valid_o=1 holds 0x88; overrun_o pulses once at the second stop sample. Raising ready_i then gives one transfer of 0x88, and valid_o drops.
4. Send 0xA5 with the stop bit driven 0 -> frame_err_o pulses once, valid_o stays 0. A following good 0x5A is received correctly after rx_i returns high.
5. 5-cycle low glitch on an idle line -> FSM returns to IDLE at the mid-sample; no valid_o or error pulses. A subsequent 0xFF is received.
6. reset_i asserted for 1 cycle mid-way through the data bits of 0x3C -> all outputs 0 the next cycle; no valid_o for the broken frame. The next full 0xC3 frame is received correctly.
